pixel_fetch: RTL and testbench

//  Downstream stage of the zoom mapper. Takes mapped image coordinates (x_img, y_img, valid)
//  and computes the linear frame-buffer address. Issues reads to the synchronous image RAM
//  and returns pixels in order through a credit-controlled output FIFO with a valid/ready

---
 rtl/pixel_fetch_if.sv | 26 ++
 rtl/pixel_fetch.sv | 82 ++++++++
 tb/tb_pixel_fetch.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/pixel_fetch_if.sv
// pixel_fetch_if: coordinate input, image RAM read port and pixel output stream of pixel_fetch.
interface pixel_fetch_if #(
   parameter int XW = 8,
   parameter int YW = 7,
   parameter int ADDR_W = 15,
   parameter int PIXEL_W = 8
);
   logic [XW-1:0] in_x;
   logic [YW-1:0] in_y;
   logic in_valid;
   logic in_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic mem_rd_en;
   logic [PIXEL_W-1:0] mem_rdata;
   logic [PIXEL_W-1:0] pixel_data;
   logic pixel_valid;
   logic pixel_ready;
   modport slave (
      input in_x, in_y, in_valid, mem_rdata, pixel_ready,
      output in_ready, mem_addr, mem_rd_en, pixel_data, pixel_valid
   );
   modport master (
      output in_x, in_y, in_valid, mem_rdata, pixel_ready,
      input in_ready, mem_addr, mem_rd_en, pixel_data, pixel_valid
   );
endinterface

// File: rtl/pixel_fetch.sv
// pixel_fetch: maps image coordinates to frame-buffer reads and returns pixels in order
// through a credit-controlled FIFO; out-of-range coordinates yield BLANK_VALUE without a read.
module pixel_fetch #(
   parameter int WIDTH_IN = 160,
   parameter int HEIGHT_IN = 120,
   parameter int PIXEL_W = 8,
   parameter int MEM_LATENCY = 1,
   parameter int BLANK_VALUE = 0
) (
   input logic clk,
   input logic reset,
   input logic flow_enabled,
   output logic busy,
   pixel_fetch_if.slave bus
);
   localparam int XW = $clog2(WIDTH_IN);
   localparam int YW = $clog2(HEIGHT_IN);
   localparam int ADDR_W = $clog2(WIDTH_IN * HEIGHT_IN);
   localparam int DEPTH = MEM_LATENCY + 3;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   logic oor, rdy, accept, push, pop;
   logic [ADDR_W-1:0] addr, mem_addr_q, mem_addr_d;
   logic [MEM_LATENCY:0] vld_q, vld_d, rd_q, rd_d;
   logic [CW-1:0] infl_q, infl_d, cnt_q, cnt_d;
   logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [PIXEL_W-1:0] wdata;
   logic [PIXEL_W-1:0] fifo_q [DEPTH];
   logic [PIXEL_W-1:0] fifo_d [DEPTH];

   // credits count both queued pixels and reads still travelling, so a push can never find the FIFO full
   always_comb begin
      oor = ({1'b0, bus.in_x} >= (XW+1)'(WIDTH_IN)) || ({1'b0, bus.in_y} >= (YW+1)'(HEIGHT_IN));
      addr = ADDR_W'(bus.in_y) * ADDR_W'(WIDTH_IN) + ADDR_W'(bus.in_x);
      rdy = reset && flow_enabled && (({1'b0, cnt_q} + {1'b0, infl_q}) < (CW+1)'(DEPTH));
      accept = bus.in_valid && rdy;
      push = vld_q[MEM_LATENCY];
      pop = (cnt_q != '0) && bus.pixel_ready;
      wdata = rd_q[MEM_LATENCY] ? bus.mem_rdata : PIXEL_W'(BLANK_VALUE);
      mem_addr_d = accept ? addr : mem_addr_q;
      vld_d = {vld_q[MEM_LATENCY-1:0], accept};
      rd_d = {rd_q[MEM_LATENCY-1:0], accept && !oor};
      infl_d = infl_q + CW'(accept) - CW'(push);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
      wp_d = push ? ((wp_q == PW'(DEPTH - 1)) ? '0 : wp_q + PW'(1)) : wp_q;
      rp_d = pop ? ((rp_q == PW'(DEPTH - 1)) ? '0 : rp_q + PW'(1)) : rp_q;
      fifo_d = fifo_q;
      if (push) fifo_d[wp_q] = wdata;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_addr_q <= '0;
         vld_q <= '0;
         rd_q <= '0;
         infl_q <= '0;
         cnt_q <= '0;
         wp_q <= '0;
         rp_q <= '0;
         fifo_q <= '{default: '0};
      end else begin
         mem_addr_q <= mem_addr_d;
         vld_q <= vld_d;
         rd_q <= rd_d;
         infl_q <= infl_d;
         cnt_q <= cnt_d;
         wp_q <= wp_d;
         rp_q <= rp_d;
         fifo_q <= fifo_d;
      end
   end

   assign bus.in_ready = rdy;
   assign bus.mem_addr = mem_addr_q;
   assign bus.mem_rd_en = rd_q[0];
   assign bus.pixel_valid = cnt_q != '0;
   assign bus.pixel_data = (cnt_q != '0) ? fifo_q[rp_q] : '0;
   assign busy = (infl_q != '0) || (cnt_q != '0);

   a_no_push_full: assert property (@(posedge clk) disable iff (!reset) !(push && cnt_q == CW'(DEPTH)));
endmodule

// File: tb/tb_pixel_fetch.sv
// tb_pixel_fetch: scoreboard bench for pixel_fetch with a one-cycle synchronous RAM model.
module tb_pixel_fetch;
   logic clk, reset, flow_enabled, busy;
   int total = 0, bad = 0, cyc = 0, n_acc = 0;
   bit chk_lat = 0;
   typedef struct { logic [7:0] pix; int cyc; } ent_t;
   ent_t sb[$];
   logic [14:0] aq[$];

   pixel_fetch_if #(.XW(8), .YW(7), .ADDR_W(15), .PIXEL_W(8)) bus();

   pixel_fetch dut (.clk(clk), .reset(reset), .flow_enabled(flow_enabled), .busy(busy), .bus(bus.slave));

   initial clk = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] ram_f(input logic [14:0] a);
      return a[7:0] ^ {1'b0, a[14:8]} ^ 8'hA5;
   endfunction

   always @(posedge clk) bus.mem_rdata <= bus.mem_rd_en ? ram_f(bus.mem_addr) : 8'h3C;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      int x, y, a;
      ent_t e;
      if (!reset) begin
         sb.delete();
         aq.delete();
      end else begin
         if (bus.mem_rd_en) begin
            if (aq.size() == 0) chk("rd_spurious", bus.mem_rd_en, 0);
            else chk("mem_addr", bus.mem_addr, aq.pop_front());
         end
         if (bus.pixel_valid && bus.pixel_ready) begin
            if (sb.size() == 0) chk("pix_spurious", bus.pixel_valid, 0);
            else begin
               e = sb.pop_front();
               chk("pix", bus.pixel_data, e.pix);
               if (chk_lat) chk("latency", cyc - e.cyc, 3);
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            n_acc++;
            x = bus.in_x;
            y = bus.in_y;
            a = y * 160 + x;
            if (x >= 160 || y >= 120) sb.push_back('{8'h00, cyc});
            else begin
               sb.push_back('{ram_f(a[14:0]), cyc});
               aq.push_back(a[14:0]);
            end
         end
      end
   end

   task automatic drive(input int x, input int y);
      bus.in_valid = 1;
      bus.in_x = 8'(x);
      bus.in_y = 7'(y);
      @(posedge clk);
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 60 && (busy || sb.size() != 0); i++) step();
      chk("idle_busy", busy, 0);
      chk("idle_sb", sb.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      int n0, drops;
      reset = 0;
      flow_enabled = 1;
      bus.in_valid = 0;
      bus.in_x = 0;
      bus.in_y = 0;
      bus.pixel_ready = 1;
      repeat (3) step();
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_rd_en", bus.mem_rd_en, 0);
      chk("rst_addr", bus.mem_addr, 0);
      chk("rst_pvalid", bus.pixel_valid, 0);
      chk("rst_pdata", bus.pixel_data, 0);
      chk("rst_busy", busy, 0);
      reset = 1;
      #1;
      chk("rel_in_ready", bus.in_ready, 1);
      // 1: back-to-back reads
      chk_lat = 1;
      drive(0, 0);
      chk("t1_addr0", bus.mem_addr, 0);
      chk("t1_rd0", bus.mem_rd_en, 1);
      drive(1, 0);
      chk("t1_addr1", bus.mem_addr, 1);
      drive(159, 119);
      chk("t1_addr2", bus.mem_addr, 19199);
      bus.in_valid = 0;
      wait_idle();
      // 2: out-of-range coordinates
      drive(160, 5);
      chk("t2_rd0", bus.mem_rd_en, 0);
      drive(3, 120);
      chk("t2_rd1", bus.mem_rd_en, 0);
      bus.in_valid = 0;
      step();
      chk("t2_rd2", bus.mem_rd_en, 0);
      wait_idle();
      // 3: backpressure fills exactly DEPTH credits
      chk_lat = 0;
      bus.pixel_ready = 0;
      n0 = n_acc;
      for (int i = 0; i < 10; i++) drive($urandom_range(159), $urandom_range(119));
      bus.in_valid = 0;
      chk("t3_accepts", n_acc - n0, 4);
      chk("t3_in_ready", bus.in_ready, 0);
      chk("t3_hold", bus.pixel_data, sb[0].pix);
      bus.pixel_ready = 1;
      wait_idle();
      chk("t3_recover", bus.in_ready, 1);
      // 4: sustained stream
      chk_lat = 1;
      n0 = n_acc;
      drops = 0;
      for (int i = 0; i < 100; i++) begin
         bus.in_valid = 1;
         bus.in_x = 8'($urandom_range(175));
         bus.in_y = 7'($urandom_range(127));
         @(negedge clk);
         if (!bus.in_ready) drops++;
         step();
      end
      bus.in_valid = 0;
      chk("t4_drops", drops, 0);
      chk("t4_accepts", n_acc - n0, 100);
      wait_idle();
      // 5: reset with reads in flight and one FIFO entry
      chk_lat = 0;
      bus.pixel_ready = 0;
      drive(10, 10);
      drive(11, 10);
      drive(12, 10);
      bus.in_valid = 0;
      chk("t5_pre_valid", bus.pixel_valid, 1);
      chk("t5_pre_busy", busy, 1);
      reset = 0;
      #1;
      chk("t5_valid", bus.pixel_valid, 0);
      chk("t5_busy", busy, 0);
      chk("t5_in_ready", bus.in_ready, 0);
      repeat (2) step();
      reset = 1;
      bus.pixel_ready = 1;
      repeat (3) step();
      chk("t5_late", bus.pixel_valid, 0);
      chk("t5_busy_after", busy, 0);
      chk_lat = 1;
      drive(42, 7);
      bus.in_valid = 0;
      wait_idle();
      // 6: flow_enabled dropped mid-stream
      n0 = 0;
      for (int i = 0; i < 20; i++) begin
         flow_enabled = !(i >= 8 && i <= 12);
         if (i == 8) n0 = n_acc;
         bus.in_valid = 1;
         bus.in_x = 8'($urandom_range(159));
         bus.in_y = 7'($urandom_range(119));
         #1;
         if (!flow_enabled) chk("t6_rdy_off", bus.in_ready, 0);
         @(posedge clk);
         #1;
         if (i == 12) chk("t6_accepts", n_acc - n0, 0);
      end
      bus.in_valid = 0;
      flow_enabled = 1;
      wait_idle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
